// File: rtl/poly_lift_pkg.sv
// poly_lift_pkg: ternary digit arithmetic, beat-count helper and FSM states
// shared by the streaming lift datapath.
package poly_lift_pkg;
    localparam logic [1:0] TER_ZERO = 2'b00;
    localparam logic [1:0] TER_POS = 2'b01;
    localparam logic [1:0] TER_NEG = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, REDUCE, EMIT} state_t;

    // Signed value of a ternary digit; the illegal code 10 reads as zero.
    function automatic int ter_to_q(input logic [1:0] a);
        return (a == TER_POS) ? 1 : (a == TER_NEG) ? -1 : 0;
    endfunction

    function automatic logic [1:0] ter_norm(input int v);
        return (v == 1 || v == -2) ? TER_POS : (v == -1 || v == 2) ? TER_NEG : TER_ZERO;
    endfunction

    function automatic logic [1:0] ter_add(input logic [1:0] a, input logic [1:0] b);
        return ter_norm(ter_to_q(a) + ter_to_q(b));
    endfunction

    function automatic logic [1:0] ter_sub(input logic [1:0] a, input logic [1:0] b);
        return ter_norm(ter_to_q(a) - ter_to_q(b));
    endfunction

    function automatic logic [1:0] ter_mul(input logic [1:0] a, input logic [1:0] b);
        return ter_norm(ter_to_q(a) * ter_to_q(b));
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/poly_lift_stream_if.sv
// poly_lift_stream_if: input and output valid/ready streams of the lift block.
interface poly_lift_stream_if #(
    parameter int LANES = 2,
    parameter int OUT_LANES = 4,
    parameter int Q_BITS = 13
);
    logic in_valid, in_ready;
    logic [2*LANES-1:0] in_data;
    logic out_valid, out_ready;
    logic [Q_BITS*OUT_LANES-1:0] out_data;

    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/lift_acc_slice.sv
// lift_acc_slice: one mod-3 product accumulator coefficient, summing LANES
// digit products per accepted beat.
module lift_acc_slice
    import poly_lift_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic set,
    input  logic [2*LANES-1:0] m,
    input  logic [2*LANES-1:0] zd,
    output logic [1:0] acc
);
    logic [1:0] sum;

    always_comb begin
        sum = TER_ZERO;
        for (int j = 0; j < LANES; j++) sum = ter_add(sum, ter_mul(m[2*j+:2], zd[2*j+:2]));
    end

    // set overwrites instead of adding so the first beat of a job drops the previous result
    always_ff @(posedge clk or negedge rst)
        if (!rst) acc <= TER_ZERO;
        else if (clr) acc <= TER_ZERO;
        else if (en) acc <= set ? sum : ter_add(acc, sum);
endmodule

// File: rtl/poly_lift_stream.sv
// poly_lift_stream: streams m*z mod (3, x^N-1), reduces mod Phi_n, multiplies
// by (x-1) and emits the Rq coefficients OUT_LANES per beat.
module poly_lift_stream
    import poly_lift_pkg::*;
#(
    parameter int NTRU_N = 701,
    parameter int Q_BITS = 13,
    parameter int LANES = 2,
    parameter int OUT_LANES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic [2*NTRU_N-1:0] z,
    output logic busy,
    poly_lift_stream_if.slave bus
);
    localparam int IN_BEATS = ceil_div(NTRU_N, LANES);
    localparam int OUT_BEATS = ceil_div(NTRU_N, OUT_LANES);
    localparam int ICW = $clog2(IN_BEATS + 1);
    localparam int OCW = $clog2(OUT_BEATS + 1);

    state_t state, state_n;
    logic [ICW-1:0] beat_cnt;
    logic [OCW-1:0] out_cnt;
    logic [2*NTRU_N-1:0] z_reg, z_src, acc, m2, m2_n, src;
    logic [2*NTRU_N+1:0] s_ext;
    logic [2*LANES-1:0] m_in;
    logic [Q_BITS*OUT_LANES-1:0] beat_n;
    logic accept, in_last, out_last, out_fire;

    assign bus.in_ready = state == IDLE || state == LOAD;
    assign bus.out_valid = state == EMIT;
    assign busy = state != IDLE;
    assign accept = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign in_last = beat_cnt == ICW'(IN_BEATS - 1);
    assign out_last = out_cnt == OCW'(OUT_BEATS - 1);
    assign z_src = state == IDLE ? z : z_reg;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        if (clear) state_n = IDLE;
        else if (accept) state_n = in_last ? REDUCE : LOAD;
        else if (state == REDUCE) state_n = EMIT;
        else if (out_fire && out_last) state_n = IDLE;
    end

    always_comb begin
        m_in = '0;
        for (int j = 0; j < LANES; j++)
            if (int'(beat_cnt) * LANES + j < NTRU_N) m_in[2*j+:2] = bus.in_data[2*j+:2];
    end

    // z_src holds z*x^(LANES*k), so lane j of coefficient i needs its digit (i-j) mod N
    for (genvar i = 0; i < NTRU_N; i++) begin : g_acc
        logic [2*LANES-1:0] zd;
        always_comb begin
            zd = '0;
            for (int j = 0; j < LANES; j++) zd[2*j+:2] = z_src[2*((i - j + NTRU_N) % NTRU_N)+:2];
        end
        lift_acc_slice #(.LANES(LANES)) u_slice (
            .clk(clk),
            .rst(rst),
            .clr(clear),
            .en(accept && !clear),
            .set(state == IDLE),
            .m(m_in),
            .zd(zd),
            .acc(acc[2*i+:2])
        );
    end

    always_comb begin
        m2_n = '0;
        for (int k = 0; k < NTRU_N; k++) m2_n[2*k+:2] = ter_sub(acc[2*k+:2], acc[2*NTRU_N-1-:2]);
    end

    // Beat 0 is built from the reduction as it is registered, later beats from m2
    assign src = state == REDUCE ? m2_n : m2;
    assign s_ext = {src, TER_ZERO};

    always_comb begin
        beat_n = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            int idx;
            idx = (state == REDUCE ? 0 : int'(out_cnt) + 1) * OUT_LANES + j;
            if (idx < NTRU_N)
                beat_n[Q_BITS*j+:Q_BITS] = Q_BITS'(ter_to_q(s_ext[2*idx+:2]) - ter_to_q(s_ext[2*idx+2+:2]));
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            z_reg <= '0;
            beat_cnt <= '0;
            out_cnt <= '0;
            m2 <= '0;
            bus.out_data <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            out_cnt <= '0;
        end else begin
            if (accept) begin
                z_reg <= {z_src[2*(NTRU_N-LANES)-1:0], z_src[2*NTRU_N-1-:2*LANES]};
                beat_cnt <= in_last ? '0 : beat_cnt + 1'b1;
            end
            if (state == REDUCE) m2 <= m2_n;
            if (state == REDUCE || (out_fire && !out_last)) bus.out_data <= beat_n;
            if (out_fire) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        end
endmodule

// File: tb/tb_poly_lift_stream.sv
// tb_poly_lift_stream: directed lift jobs at N=5 with a queued scoreboard
// checked by an independent output monitor.
module tb_poly_lift_stream;
    import poly_lift_pkg::*;
    localparam int N = 5, L = 2, OL = 2, Q = 13;
    typedef int vec_t[N];
    typedef logic [Q-1:0] qvec_t[N];

    logic clk = 0, rst = 0, clear = 0, busy;
    logic [2*N-1:0] z = '0;
    int vecs = 0, errs = 0;
    logic [Q*OL-1:0] exp_q[$];
    logic [Q*OL-1:0] exp_beat, last_data = '0;
    bit last_stall = 0;

    poly_lift_stream_if #(.LANES(L), .OUT_LANES(OL), .Q_BITS(Q)) bus ();
    poly_lift_stream #(.NTRU_N(N), .Q_BITS(Q), .LANES(L), .OUT_LANES(OL)) dut (
        .clk(clk), .rst(rst), .clear(clear), .z(z), .busy(busy), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] enc(input int v, input bit ill);
        return v == 1 ? TER_POS : v == -1 ? TER_NEG : ill ? 2'b10 : TER_ZERO;
    endfunction

    function automatic logic [2*N-1:0] pack(input vec_t v);
        logic [2*N-1:0] r;
        for (int i = 0; i < N; i++) r[2*i+:2] = enc(v[i], 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_beat: got %0h expected none", bus.out_data);
            end else begin
                exp_beat = exp_q.pop_front();
                chk("out_beat", bus.out_data, exp_beat);
            end
        end
        if (last_stall && bus.out_valid) chk("hold_stable", bus.out_data, last_data);
        last_stall = bus.out_valid && !bus.out_ready;
        last_data = bus.out_data;
    end

    task automatic send(input logic [2*L-1:0] d, output bit first_ok);
        int n = 0;
        bit hs;
        bus.in_valid = 1;
        bus.in_data = d;
        do begin
            hs = bus.in_ready;
            tick();
            n++;
        end while (!hs && n < 20);
        chk("in_handshake", hs, 1);
        first_ok = hs && n == 1;
    endtask

    // The unused lane of the last beat carries +1 and z is scrambled after beat 0; both must be ignored
    task automatic feed(input vec_t zv, input vec_t mv, input bit gaps, input bit ill, output bit first_ok);
        bit ok;
        z = pack(zv);
        for (int b = 0; b < 3; b++) begin
            if (gaps && b > 0) begin
                bus.in_valid = 0;
                repeat ($urandom_range(1, 3)) tick();
            end
            send({2*b+1 < N ? enc(mv[2*b+1], ill) : TER_POS, enc(mv[2*b], ill)}, ok);
            if (b == 0) begin
                first_ok = ok;
                z = '1;
            end
        end
        bus.in_valid = 0;
    endtask

    task automatic drain(input bit stall);
        int n = 0;
        bit leak = 0;
        chk("reduce_out_valid", bus.out_valid, 0);
        chk("reduce_in_ready", bus.in_ready, 0);
        chk("reduce_busy", busy, 1);
        tick();
        chk("emit_out_valid", bus.out_valid, 1);
        if (stall) begin
            tick();
            bus.out_ready = 0;
            repeat (4) tick();
            bus.out_ready = 1;
        end
        while (busy && n < 20) begin
            leak |= bus.in_ready;
            tick();
            n++;
        end
        chk("job_done", busy, 0);
        chk("in_ready_low_while_busy", leak, 0);
        chk("idle_in_ready", bus.in_ready, 1);
    endtask

    task automatic job(input vec_t zv, input vec_t mv, input qvec_t em, input bit gaps, input bit ill,
                       input bit stall, output bit first_ok);
        logic [Q-1:0] hi;
        for (int b = 0; b < 3; b++) begin
            hi = (2*b+1 < N) ? em[2*b+1] : '0;
            exp_q.push_back({hi, em[2*b]});
        end
        feed(zv, mv, gaps, ill, first_ok);
        drain(stall);
    endtask

    initial begin
        bit ok;
        bus.in_valid = 0;
        bus.in_data = '0;
        bus.out_ready = 1;
        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", bus.out_data, 0);
        rst = 1;
        tick();
        chk("rst_in_ready", bus.in_ready, 1);

        job('{1, 0, 0, 0, 0}, '{1, 0, -1, 0, 0}, '{13'h1fff, 13'h1, 13'h1, 13'h1fff, 13'h0}, 0, 0, 0, ok);
        job('{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{13'h1, 13'h0, 13'h0, 13'h0, 13'h1fff}, 0, 1, 0, ok);
        job('{0, 1, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{13'h1fff, 13'h1, 13'h0, 13'h0, 13'h0}, 0, 0, 0, ok);
        job('{0, 1, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{13'h1fff, 13'h1, 13'h0, 13'h0, 13'h0}, 1, 0, 0, ok);
        job('{1, 1, 1, 0, 0}, '{1, 1, 0, 0, 0}, '{13'h1fff, 13'h2, 13'h0, 13'h1ffe, 13'h1}, 0, 0, 1, ok);

        // clear coinciding with the second input beat
        z = pack('{1, 0, 0, 0, 0});
        send({TER_ZERO, TER_POS}, ok);
        chk("load_busy", busy, 1);
        bus.in_data = {TER_POS, TER_POS};
        clear = 1;
        tick();
        clear = 0;
        bus.in_valid = 0;
        chk("clear_busy", busy, 0);
        chk("clear_in_ready", bus.in_ready, 1);
        chk("clear_out_valid", bus.out_valid, 0);
        job('{1, 0, 0, 0, 0}, '{1, 0, -1, 0, 0}, '{13'h1fff, 13'h1, 13'h1, 13'h1fff, 13'h0}, 0, 0, 0, ok);

        // asynchronous reset while EMIT holds a stalled beat
        bus.out_ready = 0;
        feed('{1, 1, 1, 0, 0}, '{1, 1, 0, 0, 0}, 0, 0, ok);
        tick();
        chk("pre_rst_out_valid", bus.out_valid, 1);
        #2 rst = 0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_busy", busy, 0);
        tick();
        rst = 1;
        bus.out_ready = 1;
        tick();
        chk("post_rst_in_ready", bus.in_ready, 1);

        job('{1, 1, 1, 0, 0}, '{1, 1, 0, 0, 0}, '{13'h1fff, 13'h2, 13'h0, 13'h1ffe, 13'h1}, 0, 0, 0, ok);
        job('{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{13'h1, 13'h0, 13'h0, 13'h0, 13'h1fff}, 0, 0, 0, ok);
        chk("b2b_first_beat", ok, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/poly_lift_stream.md
Name: poly_lift_stream

Overview:
- Streaming, parametrised successor of the wide single-shot ternary lift used in the NTRU-HRSS KEM datapath.
- Accepts message m (ternary, NTRU_N coefficients) LANES coefficients per beat and multiplies it by the static ternary vector z (inverse of Phi1) mod (3, x^N-1).
- Reduces mod Phi_n, multiplies by (x-1) and streams the result in Rq, OUT_LANES coefficients per beat.
- Valid/ready handshakes on both sides, with a FSM replacing the free-running enable.

Parameters:
- NTRU_N, 701: polynomial length.
- Q_BITS, 13: output coefficient width (mod 2^Q_BITS).
- LANES, 2: input coefficients per beat.
- OUT_LANES, 4: output coefficients per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns to IDLE.
- z  in  2*NTRU_N  static ternary z vector, coefficient i at [2i+1:2i]; sampled at the first accepted input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts input beat.
- in_data  in  2*LANES  ternary lanes; lane j at [2j+1:2j] = m[LANES*k+j] for beat k.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts output beat.
- out_data  out  Q_BITS*OUT_LANES  lane j = m0[OUT_LANES*k+j].
- busy  out  1  high in any state except IDLE.

Behaviour:
- Ternary code (all 2-bit fields): 00=0, 01=+1, 11=-1. 10 is illegal and is treated as 0 on input.
- Derived constants: IN_BEATS=ceil(N/LANES), OUT_BEATS=ceil(N/OUT_LANES).
- Reset (rst=0, async): state IDLE, all counters, accumulator, z_reg and out_data = 0; out_valid=0, busy=0. in_ready=1 once rst releases.
- States: IDLE, LOAD, REDUCE, EMIT.
- in_ready=1 in IDLE and LOAD only. out_valid=1 in EMIT only.
- IDLE: on the first in_valid&in_ready:
  - z_reg <= z;
  - acc <= beat contribution computed with z;
  - beat_cnt=1; go to LOAD (or REDUCE if IN_BEATS=1).
- LOAD, per accepted beat k: acc[i] += sum_j m[Lk+j] * z[(i-Lk-j) mod N], mod 3.
  - Implementation: z_reg rotates left by LANES coefficients per accepted beat.
  - Lanes with index >= N in the last beat are ignored.
  - No beat accepted means no state change (gaps allowed).
- After beat IN_BEATS-1 is accepted, go to REDUCE.
- REDUCE (exactly 1 cycle): m2[i] = acc[i] - acc[N-1] (mod 3), registered. Go to EMIT.
- EMIT:
  - m0[i] = (m2[i-1] - m2[i]) mod 2^Q_BITS, with m2[-1]=0. Sign-extend ternary to Q_BITS before subtracting.
  - out_data is registered and held stable while out_valid & !out_ready.
  - Lanes with index >= N on the last beat are driven 0.
  - After handshake of beat OUT_BEATS-1, go to IDLE; in_ready=1 the next cycle.
- Latency: last input handshake at cycle t gives REDUCE at t+1 and out_valid=1 with beat 0 at t+2.
- clear=1 (synchronous): next state IDLE, counters and acc zeroed, out_valid=0. clear has priority over any simultaneous handshake, and any in-flight data is discarded.
- Reset mid-operation: immediate return to the reset values; no partial output.
- Changes to z after the first beat are ignored until the next IDLE->LOAD.

Decomposition:
- Package poly_lift_pkg:
  - ternary code localparams (TER_ZERO, TER_POS, TER_NEG);
  - functions ter_add, ter_sub, ter_mul, ter_to_q (sign-extend to Q_BITS);
  - ceil-div function for beat counts;
  - state enum.
- Sub-module lift_acc_slice (one per coefficient, NTRU_N instances):
  - takes LANES input digits and the LANES matching rotated z digits;
  - holds one acc coefficient with clear and load-enable.
- FSM, counters, reduction and output mux stay in the top level.

Test Plan: (all with NTRU_N=5, LANES=2, OUT_LANES=2, Q_BITS=13, so 3 beats in and 3 beats out)
- z=1 (z[0]=+1), m=[+1,0,-1,0,0] -> m0 = [1FFF, 0001, 0001, 1FFF, 0000]; out_valid rises 2 cycles after the last input handshake.
- z=1, m=[0,0,0,0,+1] -> reduction path: m2=[-1,-1,-1,-1,0], m0 = [0001, 0000, 0000, 0000, 1FFF]; last out beat lane1 = 0.
- z=x (z[1]=+1), m=[0,0,0,0,+1] -> wrap-around: acc=[+1,0,0,0,0], m0 = [1FFF, 0001, 0, 0, 0]. Also insert random in_valid gaps and verify identical output.
- z=1+x+x^2, m=1+x -> mod-3 accumulation: acc=[+1,-1,-1,+1,0], m0 = [1FFF, 0002, 0000, 1FFE, 0001]. Hold out_ready=0 for 4 cycles on beat 1 and check out_data is stable.
- Reset/clear: clear pulsed during LOAD beat 1 (coinciding with in_valid) -> beat not absorbed, state IDLE, busy=0. rst=0 asserted in EMIT -> out_valid=0 asynchronously. A following full job produces correct results.
- Back-to-back jobs: second job's first beat offered the cycle after the last out handshake is accepted; in_ready=0 throughout REDUCE/EMIT.
